// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between CPU fetch and data ports.
// Optional starvation guard for fetch: define MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,

  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,

  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_cfg
    $error("mem_arbiter: STARVE_MAX must be in 1..15");
  end

  logic owner_i;
  logic owner_d;
  logic owner_wr;
  logic force_i;

  // Byte-offset bits are dropped; RAM is word addressed.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{i_addr[1:0], d_addr[1:0]};

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!i_req || i_gnt) begin
      starve_cnt <= '0;
    end else if (d_gnt && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign force_i = i_req & (starve_cnt == STARVE_LIM);
`else
  assign force_i = 1'b0;
`endif

  // Grants are purely combinational so a winning requester sees gnt in its req cycle.
  always_comb begin
    d_gnt     = rst_n & d_req & ~force_i;
    i_gnt     = rst_n & i_req & (~d_req | force_i);
    mem_en    = i_gnt | d_gnt;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (d_gnt) begin
      mem_addr  = {d_addr[31:2], 2'b00};
      mem_wdata = d_wdata;
      mem_be    = d_be;
    end else if (i_gnt) begin
      mem_addr  = {i_addr[31:2], 2'b00};
      mem_wdata = d_wdata;
      mem_be    = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_i  <= 1'b0;
      owner_d  <= 1'b0;
      owner_wr <= 1'b0;
    end else begin
      owner_i  <= i_gnt;
      owner_d  <= d_gnt;
      owner_wr <= d_gnt & (|d_be);
    end
  end

  // Responses are masked while reset is asserted so a grant just before reset never completes.
  always_comb begin
    i_rvalid = rst_n & owner_i;
    d_rvalid = rst_n & owner_d;
    i_rdata  = i_rvalid ? mem_rdata : 32'h0;
    d_rdata  = (d_rvalid & ~owner_wr) ? mem_rdata : 32'h0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: RAM model, behavioural reference and directed vectors.
module tb_mem_arbiter;

  localparam int unsigned SMAX = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD_ON = 1'b1;
`else
  localparam bit GUARD_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        mem_en;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // RAM driven by the DUT and a separate reference copy driven by the model.
  logic [31:0] ram     [0:1023];
  logic [31:0] ref_mem [0:1023];

  initial begin
    for (int k = 0; k < 1024; k++) begin
      ram[k]     = 32'hC0DE_0000 | 32'(k);
      ref_mem[k] = 32'hC0DE_0000 | 32'(k);
    end
    ram[32'h200 >> 2]     = 32'h1111_1111;
    ref_mem[32'h200 >> 2] = 32'h1111_1111;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (|mem_be) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr[11:2]];
      end
    end
  end

  // Reference model: who was served last cycle, what data they should see,
  // and how many consecutive cycles a pending fetch has lost to data.
  logic        m_resp_i  = 1'b0;
  logic        m_resp_d  = 1'b0;
  logic        m_resp_wr = 1'b0;
  logic [31:0] m_rdata   = 32'h0;
  int          m_losses  = 0;

  always @(negedge clk) begin
    logic        frc, eg_i, eg_d, d_write;
    logic [31:0] ea;
    frc     = GUARD_ON && i_req && (m_losses >= int'(SMAX));
    eg_d    = rst_n && d_req && !frc;
    eg_i    = rst_n && i_req && (!d_req || frc);
    d_write = eg_d && (d_be != 4'h0);
    ea      = eg_d ? (d_addr & ~32'h3) : (eg_i ? (i_addr & ~32'h3) : 32'h0);

    chk("i_gnt", 32'(i_gnt), 32'(eg_i));
    chk("d_gnt", 32'(d_gnt), 32'(eg_d));
    chk("mem_en", 32'(mem_en), 32'(eg_i || eg_d));
    chk("mem_addr", mem_addr, ea);
    chk("mem_be", 32'(mem_be), eg_d ? 32'(d_be) : 32'h0);
    if (!eg_i) chk("mem_wdata", mem_wdata, eg_d ? d_wdata : 32'h0);
    chk("i_rvalid", 32'(i_rvalid), 32'(rst_n && m_resp_i));
    chk("d_rvalid", 32'(d_rvalid), 32'(rst_n && m_resp_d));
    chk("i_rdata", i_rdata, (rst_n && m_resp_i) ? m_rdata : 32'h0);
    chk("d_rdata", d_rdata, (rst_n && m_resp_d && !m_resp_wr) ? m_rdata : 32'h0);

    if (!rst_n) begin
      m_resp_i  <= 1'b0;
      m_resp_d  <= 1'b0;
      m_resp_wr <= 1'b0;
      m_losses  <= 0;
    end else begin
      m_resp_i  <= eg_i;
      m_resp_d  <= eg_d;
      m_resp_wr <= d_write;
      if (!i_req || eg_i) m_losses <= 0;
      else if (eg_d && m_losses < int'(SMAX)) m_losses <= m_losses + 1;
      if (d_write) begin
        for (int b = 0; b < 4; b++)
          if (d_be[b]) ref_mem[ea[11:2]][8*b +: 8] <= d_wdata[8*b +: 8];
      end else if (eg_d || eg_i) begin
        m_rdata <= ref_mem[ea[11:2]];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  logic [11:0] ig_pat, dg_pat, rv_pat;
  logic [4:0]  post_pat;

  initial begin
    rst_n = 1'b0;
    i_req = 1'b1; i_addr = 32'h0000_0300;
    d_req = 1'b1; d_addr = 32'h0000_0200; d_wdata = 32'h0; d_be = 4'h0;

    // Reset held with both requests pending
    repeat (3) begin
      @(negedge clk);
      chk("rst_gnts", {30'h0, i_gnt, d_gnt}, 32'h0);
      chk("rst_mem_en", 32'(mem_en), 32'h0);
      chk("rst_rvalids", {30'h0, i_rvalid, d_rvalid}, 32'h0);
    end
    step(); rst_n = 1'b1;
    @(negedge clk);
    chk("rel_d_gnt", 32'(d_gnt), 32'h1);

    // Lone fetch
    step(); d_req = 1'b0; i_req = 1'b1; i_addr = 32'h0000_0106;
    @(negedge clk);
    chk("fetch_addr", mem_addr, 32'h0000_0104);
    chk("fetch_be", 32'(mem_be), 32'h0);
    chk("fetch_gnt", 32'(i_gnt), 32'h1);
    step(); i_req = 1'b0;
    @(negedge clk);
    chk("fetch_rvalid", 32'(i_rvalid), 32'h1);
    chk("fetch_rdata", i_rdata, 32'hC0DE_0041);

    // Byte-enabled write then read-back
    step(); d_req = 1'b1; d_addr = 32'h0000_0200; d_wdata = 32'h00AB_CD00; d_be = 4'b0110;
    @(negedge clk);
    chk("wr_gnt", 32'(d_gnt), 32'h1);
    chk("wr_be", 32'(mem_be), 32'h6);
    step(); d_be = 4'b0000;
    @(negedge clk);
    chk("wr_rvalid", 32'(d_rvalid), 32'h1);
    chk("wr_rdata", d_rdata, 32'h0);
    step(); d_req = 1'b0;
    @(negedge clk);
    chk("rd_rvalid", 32'(d_rvalid), 32'h1);
    chk("rd_rdata", d_rdata, 32'h11AB_CD11);

    // Sustained contention
    step(); i_req = 1'b1; i_addr = 32'h0000_0300; d_req = 1'b1; d_addr = 32'h0000_0400;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      ig_pat[k] = i_gnt;
      dg_pat[k] = d_gnt;
      rv_pat[k] = i_rvalid;
      step();
    end
    chk("cont_i_pat", 32'(ig_pat), GUARD_ON ? 32'h210 : 32'h000);
    chk("cont_d_pat", 32'(dg_pat), GUARD_ON ? 32'hDEF : 32'hFFF);
    chk("cont_rv_pat", 32'(rv_pat), GUARD_ON ? 32'h420 : 32'h000);
    d_req = 1'b0;
    @(negedge clk);
    chk("drop_d_i_gnt", 32'(i_gnt), 32'h1);

    // Reset one cycle after a data read grant
    step(); d_req = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("pre_rst_d_gnt", 32'(d_gnt), 32'h1);
    step(); rst_n = 1'b0;
    @(negedge clk);
    chk("rst_drop_rvalid", 32'(d_rvalid), 32'h0);
    chk("rst_drop_gnts", {30'h0, i_gnt, d_gnt}, 32'h0);
    step(); rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      post_pat[k] = i_gnt;
      step();
    end
    chk("post_rst_i_pat", 32'(post_pat), GUARD_ON ? 32'h10 : 32'h00);

    i_req = 1'b0; d_req = 1'b0;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
